// File: rtl/vga_drum_sequencer.sv
// ============================================================================
// Module   : vga_drum_sequencer
// Purpose  : Beam-synchronous 16-step drum machine (kick/snare/hat) producing
//            a per-scanline PWM audio bit plus one-cycle beat pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module vga_drum_sequencer #(
    parameter int          H_MAX        = 799,
    parameter int          STEP_FRAMES  = 8,
    parameter logic [15:0] KICK_PATTERN = 16'h1111,
    parameter logic [15:0] SNARE_PATTERN = 16'h4444,
    parameter logic [15:0] HAT_PATTERN  = 16'h5555,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       enable,
    output logic       audio,
    output logic [3:0] step,
    output logic [2:0] hit
);

    localparam logic [9:0]        C_H_MAX   = 10'(H_MAX);
    localparam int                C_FD_W    = $clog2(STEP_FRAMES);
    localparam logic [C_FD_W-1:0] C_FD_LAST = C_FD_W'(STEP_FRAMES - 1);

    logic [C_FD_W-1:0] frame_div_q, frame_div_d;
    logic [3:0]        step_q, step_d;
    logic [4:0]        kick_env_q, kick_env_d;
    logic [4:0]        snare_env_q, snare_env_d;
    logic [3:0]        hat_env_q, hat_env_d;
    logic [5:0]        kick_ctr_q, kick_ctr_d;
    logic              kick_sq_q, kick_sq_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [6:0]        mix_q, mix_d;
    logic              audio_q, audio_d;
    logic [2:0]        hit_q, hit_d;

    logic              w_line_tick;
    logic              w_frame_tick;
    logic [2:0]        w_trig;
    logic [5:0]        w_kick_last;
    logic              w_lfsr_fb;
    logic [6:0]        w_mix_line;
    logic [6:0]        w_mix_pwm;

    always_comb begin
        w_line_tick  = (hpos == 10'd0);
        w_frame_tick = w_line_tick && (vpos == 10'd0);

        w_trig = 3'b000;
        if (w_frame_tick && enable && (frame_div_q == '0)) begin
            w_trig = {HAT_PATTERN[step_q], SNARE_PATTERN[step_q], KICK_PATTERN[step_q]};
        end

        w_kick_last = 6'd35 - {1'b0, kick_env_q};
        w_lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        w_mix_line  = (kick_sq_q ? {2'b00, kick_env_q} : 7'd0)
                    + (lfsr_q[0] ? {2'b00, snare_env_q} : 7'd0)
                    + ((lfsr_q[3] & lfsr_q[7]) ? {3'b000, hat_env_q} : 7'd0);

        frame_div_d = frame_div_q;
        step_d      = step_q;
        kick_env_d  = kick_env_q;
        snare_env_d = snare_env_q;
        hat_env_d   = hat_env_q;
        kick_ctr_d  = kick_ctr_q;
        kick_sq_d   = kick_sq_q;
        lfsr_d      = lfsr_q;
        mix_d       = mix_q;
        hit_d       = w_trig;

        if (w_frame_tick && enable) begin
            if (frame_div_q == C_FD_LAST) begin
                frame_div_d = '0;
                step_d      = step_q + 4'd1;
            end else begin
                frame_div_d = frame_div_q + C_FD_W'(1);
            end
        end

        // Envelopes: a trigger reloads, otherwise decay saturates at zero.
        if (w_frame_tick) begin
            kick_env_d  = w_trig[0] ? 5'd31
                        : ((kick_env_q != 5'd0) ? kick_env_q - 5'd1 : 5'd0);
            snare_env_d = w_trig[1] ? 5'd31
                        : ((snare_env_q >= 5'd2) ? snare_env_q - 5'd2 : 5'd0);
            hat_env_d   = w_trig[2] ? 4'd15
                        : ((hat_env_q != 4'd0) ? hat_env_q - 4'd1 : 4'd0);
        end

        if (w_line_tick) begin
            lfsr_d = {lfsr_q[14:0], w_lfsr_fb};
            mix_d  = w_mix_line;
            if (w_trig[0]) begin
                kick_ctr_d = 6'd0;
                kick_sq_d  = 1'b1;
            end else if (kick_ctr_q >= w_kick_last) begin
                kick_ctr_d = 6'd0;
                kick_sq_d  = ~kick_sq_q;
            end else begin
                kick_ctr_d = kick_ctr_q + 6'd1;
            end
        end

        // At hpos==0 compare against the level being latched this edge, so each
        // line emits exactly mix_q high cycles instead of a stale first cycle.
        w_mix_pwm = w_line_tick ? mix_d : mix_q;
        audio_d   = (hpos <= C_H_MAX) && (hpos < {3'b000, w_mix_pwm});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_div_q <= '0;
            step_q      <= 4'd0;
            kick_env_q  <= 5'd0;
            snare_env_q <= 5'd0;
            hat_env_q   <= 4'd0;
            kick_ctr_q  <= 6'd0;
            kick_sq_q   <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            mix_q       <= 7'd0;
            audio_q     <= 1'b0;
            hit_q       <= 3'b000;
        end else begin
            frame_div_q <= frame_div_d;
            step_q      <= step_d;
            kick_env_q  <= kick_env_d;
            snare_env_q <= snare_env_d;
            hat_env_q   <= hat_env_d;
            kick_ctr_q  <= kick_ctr_d;
            kick_sq_q   <= kick_sq_d;
            lfsr_q      <= lfsr_d;
            mix_q       <= mix_d;
            audio_q     <= audio_d;
            hit_q       <= hit_d;
        end
    end

    assign audio = audio_q;
    assign step  = step_q;
    assign hit   = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_drum_sequencer.sv
// ============================================================================
// Module   : tb_vga_drum_sequencer
// Purpose  : Self-checking bench for vga_drum_sequencer with a line-level
//            reference model and expected/observed scoreboard queues.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_drum_sequencer;

    localparam int          H_MAX       = 79;
    localparam int          STEP_FRAMES = 8;
    localparam int          LINES       = 2;
    localparam logic [15:0] KICK        = 16'h1111;
    localparam logic [15:0] SNARE       = 16'h4444;
    localparam logic [15:0] HAT         = 16'h5555;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       audio;
    logic [3:0] step;
    logic [2:0] hit;

    vga_drum_sequencer #(
        .H_MAX        (H_MAX),
        .STEP_FRAMES  (STEP_FRAMES),
        .KICK_PATTERN (KICK),
        .SNARE_PATTERN(SNARE),
        .HAT_PATTERN  (HAT),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hpos  (hpos),
        .vpos  (vpos),
        .enable(enable),
        .audio (audio),
        .step  (step),
        .hit   (hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         mix;
        logic [2:0] hit;
        logic [3:0] step;
        int         hit_extra;
        bit         contig;
    } line_t;

    line_t exp_q[$];
    line_t obs_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cur_v    = 0;

    int          m_fd, m_step, m_kenv, m_senv, m_henv, m_kctr;
    bit          m_ksq;
    logic [15:0] m_lfsr;

    function automatic int model_mix();
        return (m_ksq ? m_kenv : 0) + (m_lfsr[0] ? m_senv : 0)
             + ((m_lfsr[3] && m_lfsr[7]) ? m_henv : 0);
    endfunction

    task automatic model_reset();
        m_fd = 0; m_step = 0; m_kenv = 0; m_senv = 0; m_henv = 0;
        m_kctr = 0; m_ksq = 1'b0; m_lfsr = SEED;
    endtask

    // Advance the behavioural model by one line start; returns what that line should show.
    task automatic model_line(input bit frame, input bit en, output line_t e);
        logic [2:0] trig;
        trig = 3'b000;
        if (frame && en && m_fd == 0) trig = {HAT[m_step], SNARE[m_step], KICK[m_step]};
        e.mix = model_mix();
        e.hit = trig;
        e.hit_extra = 0;
        e.contig = 1'b1;
        if (trig[0]) begin
            m_kctr = 0; m_ksq = 1'b1;
        end else if (m_kctr >= 35 - m_kenv) begin
            m_kctr = 0; m_ksq = !m_ksq;
        end else begin
            m_kctr++;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (frame) begin
            m_kenv = trig[0] ? 31 : (m_kenv > 0 ? m_kenv - 1 : 0);
            m_senv = trig[1] ? 31 : (m_senv > 2 ? m_senv - 2 : 0);
            m_henv = trig[2] ? 15 : (m_henv > 0 ? m_henv - 1 : 0);
            if (en) begin
                if (m_fd == STEP_FRAMES - 1) begin
                    m_fd = 0; m_step = (m_step + 1) % 16;
                end else begin
                    m_fd++;
                end
            end
        end
        e.step = 4'(m_step);
    endtask

    // Drive one full scanline, push the model's expectation, record what the DUT emitted.
    task automatic run_line(input bit en);
        line_t e, o;
        bit    seen_low;
        enable = en;
        model_line(cur_v == 0, en, e);
        exp_q.push_back(e);
        o = '{mix: 0, hit: 3'b000, step: 4'd0, hit_extra: 0, contig: 1'b1};
        seen_low = 1'b0;
        for (int h = 0; h <= H_MAX; h++) begin
            hpos = 10'(h);
            vpos = 10'(cur_v);
            @(posedge clk); #1;
            if (audio === 1'b1) begin
                o.mix++;
                if (seen_low) o.contig = 1'b0;
            end else begin
                seen_low = 1'b1;
            end
            if (h == 0) begin
                o.hit  = hit;
                o.step = step;
            end else if (hit !== 3'b000) begin
                o.hit_extra++;
            end
        end
        obs_q.push_back(o);
        cur_v = (cur_v + 1) % LINES;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        hpos   = 10'd17;
        vpos   = 10'd1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        cur_v = 0;
    endtask

    task automatic test_reset();
        line_t e, o;
        do_reset();
        n_checks++; if (audio !== 1'b0) begin n_fail++; $display("FAIL reset_audio got %b want 0", audio); end
        n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL reset_step got %0d want 0", step); end
        n_checks++; if (hit !== 3'b000) begin n_fail++; $display("FAIL reset_hit got %b want 000", hit); end
        run_line(1'b0);
        run_line(1'b0);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.mix !== 0) begin n_fail++; $display("FAIL reset_line%0d_mix got %0d want 0", i, o.mix); end
            n_checks++; if (o.mix !== e.mix) begin n_fail++; $display("FAIL reset_line%0d_model got %0d want %0d", i, o.mix, e.mix); end
            n_checks++; if (o.hit !== 3'b000 || o.step !== 4'd0) begin
                n_fail++; $display("FAIL reset_line%0d_seq hit %b step %0d want 000/0", i, o.hit, o.step);
            end
        end
    endtask

    task automatic test_first_trigger();
        line_t e, o;
        int    tidx;
        while (cur_v != 0) run_line(1'b0);
        tidx = obs_q.size();
        run_line(1'b1);
        run_line(1'b1);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.mix !== e.mix || !o.contig) begin
                n_fail++; $display("FAIL first_mix line%0d got %0d contig %0b want %0d", i, o.mix, o.contig, e.mix);
            end
            n_checks++; if (o.hit !== e.hit || o.hit_extra !== 0) begin
                n_fail++; $display("FAIL first_hit line%0d got %b extra %0d want %b", i, o.hit, o.hit_extra, e.hit);
            end
            if (i == tidx) begin
                n_checks++; if (o.hit !== 3'b101) begin n_fail++; $display("FAIL first_hit_value got %b want 101", o.hit); end
                n_checks++; if (o.step !== 4'd0) begin n_fail++; $display("FAIL first_step got %0d want 0", o.step); end
            end
            if (i == tidx + 1) begin
                n_checks++; if (o.mix < 31) begin n_fail++; $display("FAIL first_loud got %0d want >=31", o.mix); end
            end
        end
    endtask

    task automatic test_sequence();
        line_t      e, o;
        int         k;
        logic [2:0] want_hit;
        do_reset();
        for (int i = 0; i < 128 * LINES + 1; i++) run_line(1'b1);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.mix !== e.mix || !o.contig) begin
                n_fail++; $display("FAIL seq_mix line%0d got %0d contig %0b want %0d", i, o.mix, o.contig, e.mix);
            end
            n_checks++; if (o.hit !== e.hit || o.hit_extra !== 0) begin
                n_fail++; $display("FAIL seq_hit_model line%0d got %b extra %0d want %b", i, o.hit, o.hit_extra, e.hit);
            end
            if (i % LINES == 0) begin
                k = i / LINES;
                want_hit = {(k % 16 == 0), (k % 32 == 16), (k % 32 == 0)};
                n_checks++; if (o.hit !== want_hit) begin
                    n_fail++; $display("FAIL seq_hit tick%0d got %b want %b", k, o.hit, want_hit);
                end
                n_checks++; if (o.step !== 4'(((k + 1) / 8) % 16)) begin
                    n_fail++; $display("FAIL seq_step tick%0d got %0d want %0d", k, o.step, ((k + 1) / 8) % 16);
                end
            end
        end
    endtask

    task automatic test_decay_disabled();
        line_t e, o;
        do_reset();
        run_line(1'b1);
        for (int i = 0; i < 34 * LINES; i++) run_line(1'b0);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.mix !== e.mix || !o.contig) begin
                n_fail++; $display("FAIL decay_mix line%0d got %0d contig %0b want %0d", i, o.mix, o.contig, e.mix);
            end
            if (i > 0) begin
                n_checks++; if (o.hit !== 3'b000 || o.hit_extra !== 0 || o.step !== 4'd0) begin
                    n_fail++; $display("FAIL decay_frozen line%0d hit %b step %0d want 000/0", i, o.hit, o.step);
                end
            end
            if (i >= 32 * LINES) begin
                n_checks++; if (o.mix !== 0) begin n_fail++; $display("FAIL decay_silent line%0d got %0d want 0", i, o.mix); end
            end
        end
    endtask

    task automatic test_reset_mid();
        line_t e, o;
        bit    found;
        int    highs, tidx;
        do_reset();
        found = 1'b0;
        for (int n = 0; n < 60 * LINES && !found; n++) begin
            run_line(1'b1);
            if (obs_q[$].step == 4'd5) found = 1'b1;
        end
        for (int n = 0; n < 12 && found && model_mix() < 4; n++) run_line(1'b1);
        n_checks++; if (!found || model_mix() < 4 || m_step != 5) begin
            n_fail++; $display("FAIL mid_setup found %0b mix %0d step %0d want 1/>=4/5", found, model_mix(), m_step);
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.mix !== e.mix || o.hit !== e.hit || o.step !== e.step) begin
                n_fail++; $display("FAIL mid_pre line%0d mix %0d hit %b step %0d want %0d/%b/%0d",
                                   i, o.mix, o.hit, o.step, e.mix, e.hit, e.step);
            end
        end
        model_line(cur_v == 0, 1'b1, e);
        enable = 1'b1;
        for (int h = 0; h < 3; h++) begin
            hpos = 10'(h); vpos = 10'(cur_v);
            @(posedge clk); #1;
        end
        n_checks++; if (audio !== 1'b1 || step !== 4'd5) begin
            n_fail++; $display("FAIL mid_before audio %b step %0d want 1/5", audio, step);
        end
        reset = 1'b1; hpos = 10'd3;
        @(posedge clk); #1;
        n_checks++; if (audio !== 1'b0) begin n_fail++; $display("FAIL mid_audio got %b want 0", audio); end
        n_checks++; if (step !== 4'd0) begin n_fail++; $display("FAIL mid_step got %0d want 0", step); end
        n_checks++; if (hit !== 3'b000) begin n_fail++; $display("FAIL mid_hit got %b want 000", hit); end
        reset = 1'b0;
        model_reset();
        highs = 0;
        for (int h = 4; h <= H_MAX; h++) begin
            hpos = 10'(h);
            @(posedge clk); #1;
            if (audio !== 1'b0) highs++;
        end
        n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL mid_tail got %0d high cycles want 0", highs); end
        cur_v = (cur_v + 1) % LINES;
        while (cur_v != 0) run_line(1'b1);
        tidx = obs_q.size();
        run_line(1'b1);
        run_line(1'b1);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.mix !== e.mix || o.hit !== e.hit || o.step !== e.step) begin
                n_fail++; $display("FAIL mid_post line%0d mix %0d hit %b step %0d want %0d/%b/%0d",
                                   i, o.mix, o.hit, o.step, e.mix, e.hit, e.step);
            end
            if (i == tidx) begin
                n_checks++; if (o.hit !== 3'b101 || o.step !== 4'd0) begin
                    n_fail++; $display("FAIL mid_retrigger hit %b step %0d want 101/0", o.hit, o.step);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        hpos   = 10'd0;
        vpos   = 10'd0;
        model_reset();
        test_reset();
        test_first_trigger();
        test_sequence();
        test_decay_disabled();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
